key_sw_debounce: RTL and testbench

Input conditioning stage between the DE2-115 KEY[3:0] / SW[17:0] pins and the SOPC system's key and switch PIO inputs. Synchronises every raw input into the 50 MHz domain and debounces each bit independently against a shared millisecond tick. Drives the debounced levels straight into the PIO ports. Also emits one-cycle press, release and change pulses for hardware consumers.

---
 rtl/key_sw_debounce_pkg.sv | 22 ++
 rtl/key_sw_debounce_bit.sv | 56 +++++
 rtl/key_sw_debounce.sv | 138 +++++++++++++
 tb/tb_key_sw_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_sw_debounce_pkg.sv
// rtl/key_sw_debounce_pkg.sv - shared constants for the DE2-115 key/switch input conditioner
//
// Package de2_input_pkg: pin counts, default timing constants, debounce
// counter width and a counter-width helper used by the top and debounce_bit.
package de2_input_pkg;

    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 18;

    localparam int TICK_DIV_DEFAULT           = 50000;
    localparam int DB_TICKS_DEFAULT           = 10;
    localparam int REPEAT_DELAY_TICKS_DEFAULT = 500;
    localparam int REPEAT_RATE_TICKS_DEFAULT  = 100;

    localparam int DB_CNT_W = 4;

    // Width of a counter that has to hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_sw_debounce_bit.sv
// rtl/key_sw_debounce_bit.sv - two-flop synchroniser and tick-based debouncer for one input bit
//
// Ports:
//   clk_50  - system clock
//   reset   - synchronous, active-high
//   tick    - one-cycle debounce tick from the shared prescaler
//   din     - raw asynchronous input bit
//   db      - debounced level (registered)
//   update  - high in the cycle whose clock edge will move db to the synced level
module debounce_bit
    import de2_input_pkg::*;
#(
    parameter int   DB_TICKS    = DB_TICKS_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk_50,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic db,
    output logic update
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_TICKS - 1);

    logic                sync_1;
    logic                sync_2;
    logic [DB_CNT_W-1:0] cnt;

    // Exported so the top can register edge pulses that line up with db.
    assign update = (sync_2 != db) && tick && (cnt == CNT_LAST);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync_1 <= RESET_LEVEL;
            sync_2 <= RESET_LEVEL;
            db     <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            // Any cycle back at the db level restarts the count, tick or not.
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    db  <= sync_2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DB_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_sw_debounce.sv
// rtl/key_sw_debounce.sv - synchronise and debounce DE2-115 KEY/SW pins for the SOPC PIOs
//
// Ports:
//   clk_50       - 50 MHz system clock, sole clock
//   reset        - synchronous, active-high
//   key_n_in     - raw KEY pins, active-low
//   sw_in        - raw SW pins
//   key_db       - debounced KEY (active-low), to in_port_to_the_key
//   sw_db        - debounced SW, to in_port_to_the_sw
//   key_press    - one-cycle pulse per key on debounced 1->0 (plus auto-repeat)
//   key_release  - one-cycle pulse per key on debounced 0->1
//   sw_change    - one-cycle pulse when any sw_db bit changes
// Optional: KEY_AUTOREPEAT_EN adds per-key auto-repeat pulses on key_press.
module key_sw_debounce
    import de2_input_pkg::*;
#(
    parameter int TICK_DIV           = TICK_DIV_DEFAULT,
    parameter int DB_TICKS           = DB_TICKS_DEFAULT,
    parameter int REPEAT_DELAY_TICKS = REPEAT_DELAY_TICKS_DEFAULT,
    parameter int REPEAT_RATE_TICKS  = REPEAT_RATE_TICKS_DEFAULT
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_SW-1:0]   sw_in,
    output logic [NUM_KEYS-1:0] key_db,
    output logic [NUM_SW-1:0]   sw_db,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                sw_change
);

    if (DB_TICKS < 2 || DB_TICKS > 15 || TICK_DIV < 1 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_param
        $error("key_sw_debounce: parameter out of range");
    end

    // Tick prescaler
    localparam int               PRE_W    = cnt_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk_50) begin
        if (reset || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Per-bit debouncers
    logic [NUM_KEYS-1:0] key_upd;
    logic [NUM_SW-1:0]   sw_upd;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DB_TICKS    (DB_TICKS),
            .RESET_LEVEL (1'b1)
        ) u_db (
            .clk_50 (clk_50),
            .reset  (reset),
            .tick   (tick),
            .din    (key_n_in[i]),
            .db     (key_db[i]),
            .update (key_upd[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DB_TICKS    (DB_TICKS),
            .RESET_LEVEL (1'b0)
        ) u_db (
            .clk_50 (clk_50),
            .reset  (reset),
            .tick   (tick),
            .din    (sw_in[i]),
            .db     (sw_db[i]),
            .update (sw_upd[i])
        );
    end

    logic [NUM_KEYS-1:0] rep_fire;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                             REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int               REP_W      = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_TICKS - 1);

    logic [REP_W-1:0]    rep_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_armed;   // first repeat done, now pacing at the rate

    // A debounced edge in the same cycle always wins, so release never repeats.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rep_fire[i] = tick && !key_db[i] && !key_upd[i] &&
                          (rep_cnt[i] == (rep_armed[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clk_50) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (reset || key_upd[i]) begin
                rep_cnt[i]   <= '0;
                rep_armed[i] <= 1'b0;
            end else if (rep_fire[i]) begin
                rep_cnt[i]   <= '0;
                rep_armed[i] <= 1'b1;
            end else if (tick && !key_db[i]) begin
                rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Pulses are registered from the update strobes so they rise with db.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            key_press   <= '0;
            key_release <= '0;
            sw_change   <= 1'b0;
        end else begin
            key_press   <= (key_upd & key_db) | rep_fire;
            key_release <= key_upd & ~key_db;
            sw_change   <= |sw_upd;
        end
    end

endmodule

// File: tb/tb_key_sw_debounce.sv
// tb/tb_key_sw_debounce.sv - randomized and directed self-checking bench for key_sw_debounce
module tb_key_sw_debounce;

    localparam int TD  = 4;
    localparam int DBT = 3;
    localparam int RD  = 5;
    localparam int RR  = 2;
    localparam logic [21:0] RST_VEC = 22'h00000F;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [3:0]  key_n_in;
    logic [17:0] sw_in;
    logic [3:0]  key_db;
    logic [17:0] sw_db;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic        sw_change;

    int checks = 0;
    int errors = 0;

    // Reference model state: k counts clock edges since reset released.
    int          k;
    logic [21:0] d1, d2, mdb;
    int          last_eq [22];
    int          kp [4];
    logic [3:0]  m_press, m_rel;
    logic        m_chg;

    always #5 clk_50 = ~clk_50;

    key_sw_debounce #(
        .TICK_DIV           (TD),
        .DB_TICKS           (DBT),
        .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS  (RR)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .key_n_in    (key_n_in),
        .sw_in       (sw_in),
        .key_db      (key_db),
        .sw_db       (sw_db),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_change   (sw_change)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A bit flips at tick edge k once DB_TICKS ticks have elapsed since the
    // last edge at which the synced input still equalled the debounced level.
    task automatic model_edge(input logic r, input logic [21:0] vin);
        logic [21:0] syn;
        if (r) begin
            k = 0; d1 = RST_VEC; d2 = RST_VEC; mdb = RST_VEC;
            m_press = '0; m_rel = '0; m_chg = 1'b0;
            for (int b = 0; b < 22; b++) last_eq[b] = 0;
            for (int i = 0; i < 4; i++) kp[i] = 0;
        end else begin
            k++;
            syn = d2; d2 = d1; d1 = vin;
            m_press = '0; m_rel = '0; m_chg = 1'b0;
            for (int b = 0; b < 22; b++) begin
                if (syn[b] == mdb[b]) begin
                    last_eq[b] = k;
                end else if (k % TD == 0 && (k / TD - last_eq[b] / TD) >= DBT) begin
                    mdb[b] = syn[b];
                    last_eq[b] = k;
                    if (b < 4) begin
                        if (!syn[b]) begin
                            m_press[b] = 1'b1;
                            kp[b] = k;
                        end else begin
                            m_rel[b] = 1'b1;
                        end
                    end else begin
                        m_chg = 1'b1;
                    end
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            for (int i = 0; i < 4; i++) begin
                if (!mdb[i] && !m_press[i] && k % TD == 0) begin
                    int t;
                    t = (k - kp[i]) / TD;
                    if (t >= RD && (t - RD) % RR == 0) m_press[i] = 1'b1;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic r, input logic [3:0] kn, input logic [17:0] sw);
        reset = r; key_n_in = kn; sw_in = sw;
        model_edge(r, {sw, kn});
        @(posedge clk_50);
        #1;
        check("key_db", key_db, mdb[3:0]);
        check("sw_db", sw_db, mdb[21:4]);
        check("pulses", {key_press, key_release, sw_change}, {m_press, m_rel, m_chg});
    endtask

    initial begin
        logic [3:0]  kn;
        logic [17:0] sw;
        logic [21:0] v;
        int          lat, n;
        logic        moved;

        kn = 4'hF; sw = '0;

        // Reset and idle
        for (int i = 0; i < 3; i++) step(1'b1, kn, sw);
        check("rst_key_db", key_db, 4'hF);
        check("rst_sw_db", sw_db, 18'h0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, kn, sw);
            if ({key_press, key_release, sw_change} != 0) n++;
        end
        check("idle_pulses", n, 0);

        // Clean press of key 0
        kn[0] = 1'b0; lat = 0;
        for (int i = 0; i < 30 && key_db[0]; i++) begin
            step(1'b0, kn, sw);
            lat++;
        end
        check("key0_latency_ok", (lat >= 11 && lat <= 14), 1);
        check("key0_press_edge", key_press, 4'h1);
        check("key31_unchanged", key_db[3:1], 3'b111);
        step(1'b0, kn, sw);
        check("key0_press_one_cycle", key_press[0], 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, kn, sw);
        kn[0] = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, kn, sw);

        // Key 1 bouncing every 3 cycles
        moved = 1'b0; n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) kn[1] = ~kn[1];
            step(1'b0, kn, sw);
            if (key_db[1] !== 1'b1) moved = 1'b1;
            if (key_press[1] || key_release[1]) n++;
        end
        kn[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, kn, sw);
            if (key_db[1] !== 1'b1) moved = 1'b1;
        end
        check("key1_bounce_db", moved, 1'b0);
        check("key1_bounce_pulses", n, 0);

        // Two switches in one cycle
        sw = 18'h20001; n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, kn, sw);
            if (sw_change) begin
                n++;
                check("sw_both_bits", sw_db, 18'h20001);
            end
        end
        check("sw_change_count", n, 1);
        sw = '0;
        for (int i = 0; i < 20; i++) step(1'b0, kn, sw);

        // Reset in the middle of a key 2 count
        kn[2] = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, kn, sw);
        step(1'b1, kn, sw);
        check("key2_reset_db", key_db[2], 1'b1);
        step(1'b1, kn, sw);
        lat = 0;
        for (int i = 0; i < 30 && key_db[2]; i++) begin
            step(1'b0, kn, sw);
            lat++;
        end
        check("key2_post_reset_latency_ok", (lat >= 11 && lat <= 14), 1);
        kn[2] = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, kn, sw);

`ifdef KEY_AUTOREPEAT_EN
        // Hold key 3 for auto-repeat
        kn[3] = 1'b0; n = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, kn, sw);
            if (key_press[3]) n++;
        end
        check("key3_repeat_seen", (n >= 3), 1);
        kn[3] = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, kn, sw);
`endif

        // Random slow toggling with occasional resets
        v = {sw, kn};
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 5) == 0) v[$urandom_range(0, 21)] ^= 1'b1;
            step(($urandom_range(0, 249) == 0), v[3:0], v[21:4]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
